// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester round-robin bus arbiter:
// state encoding, requester count, default tenure limit, one-hot helper.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int unsigned NREQ    = 8;
  localparam int unsigned TMO_DEF = 16;

  function automatic logic [NREQ-1:0] onehot8(input logic [2:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arb_8_mux8.sv
// Team 8:1 mux block, width n, binary select.
module mux8 #(
  parameter int n = 8
) (
  input  logic [n-1:0] d0,
  input  logic [n-1:0] d1,
  input  logic [n-1:0] d2,
  input  logic [n-1:0] d3,
  input  logic [n-1:0] d4,
  input  logic [n-1:0] d5,
  input  logic [n-1:0] d6,
  input  logic [n-1:0] d7,
  input  logic [2:0]   sel,
  output logic [n-1:0] y
);

  always_comb begin
    y = '0;
    unique case (sel)
      3'd0: y = d0;
      3'd1: y = d1;
      3'd2: y = d2;
      3'd3: y = d3;
      3'd4: y = d4;
      3'd5: y = d5;
      3'd6: y = d6;
      3'd7: y = d7;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bus_arb_8_rr_pick8.sv
// Combinational round-robin picker: first bit of req & ~excl searching
// upward (mod 8) from last+1.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] last,
  input  logic [7:0] excl,
  output logic       any,
  output logic [2:0] idx
);

  logic [7:0] w_cand;
  logic [2:0] w_pos;
  logic       w_found;

  always_comb begin
    w_cand  = req & ~excl;
    any     = |w_cand;
    idx     = last;
    w_pos   = last;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_pos = last + 3'(k);
      if (!w_found && w_cand[w_pos]) begin
        idx     = w_pos;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arb_8.sv
// 8-requester round-robin bus arbiter with registered grant and data select.
// Optional owner-tenure limit compiled in with macro ARB_TIMEOUT_EN.
module bus_arb_8
  import arb_pkg::*;
#(
  parameter int n   = 8,
  parameter int TMO = TMO_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [7:0]   REQ,
  input  logic         REL,
  input  logic [n-1:0] D0,
  input  logic [n-1:0] D1,
  input  logic [n-1:0] D2,
  input  logic [n-1:0] D3,
  input  logic [n-1:0] D4,
  input  logic [n-1:0] D5,
  input  logic [n-1:0] D6,
  input  logic [n-1:0] D7,
  output logic [7:0]   GNT,
  output logic [2:0]   SEL,
  output logic         BUSY,
  output logic [n-1:0] D_OUT,
  output logic         D_VALID
);

  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

  if (TMO < 1) begin : g_tmo_invalid
    $error("bus_arb_8: TMO must be at least 1");
  end

  arb_state_t   r_state;
  logic [7:0]   r_gnt;
  logic [2:0]   r_sel;
  logic [2:0]   r_last;
  logic         r_busy;
  logic [n-1:0] r_dout;
  logic         r_dvalid;

  logic         w_any;
  logic [2:0]   w_idx;
  logic [7:0]   w_excl;
  logic [n-1:0] w_mux;
  logic         w_tmo;
  logic         w_rel;
  logic         w_grant;
  logic         w_drop;

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] r_cnt;
  assign w_tmo = (r_cnt == CW'(TMO - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // Owner is excluded while releasing so it competes again only from IDLE,
  // i.e. at lowest round-robin priority.
  assign w_excl  = (r_state == OWN) ? onehot8(r_sel) : '0;
  assign w_rel   = (r_state == OWN) && (REL || !REQ[r_sel] || w_tmo);
  assign w_grant = ((r_state == IDLE) || w_rel) && w_any;
  assign w_drop  = w_rel && !w_any;

  rr_pick8 u_pick (
    .req  (REQ),
    .last (r_last),
    .excl (w_excl),
    .any  (w_any),
    .idx  (w_idx)
  );

  mux8 #(.n(n)) u_mux (
    .d0  (D0),
    .d1  (D1),
    .d2  (D2),
    .d3  (D3),
    .d4  (D4),
    .d5  (D5),
    .d6  (D6),
    .d7  (D7),
    .sel (r_sel),
    .y   (w_mux)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_sel    <= '0;
      r_last   <= 3'd7;
      r_busy   <= 1'b0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_dvalid <= (r_state == OWN);
      if (r_state == OWN) r_dout <= w_mux;
      if (w_grant) begin
        r_state <= OWN;
        r_gnt   <= onehot8(w_idx);
        r_sel   <= w_idx;
        r_last  <= w_idx;
        r_busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
        r_cnt   <= '0;
`endif
      end else if (w_drop) begin
        r_state <= IDLE;
        r_gnt   <= '0;
        r_busy  <= 1'b0;
      end
`ifdef ARB_TIMEOUT_EN
      else if (r_state == OWN) begin
        r_cnt <= r_cnt + CW'(1);
      end
`endif
    end
  end

  assign GNT     = r_gnt;
  assign SEL     = r_sel;
  assign BUSY    = r_busy;
  assign D_OUT   = r_dout;
  assign D_VALID = r_dvalid;

endmodule

// File: doc/bus_arb_8.md
BUS_ARB_8 -- requirements
Module: bus_arb_8

Interface
REQ-001 Parameter n, default 8, data width of each requester word and of D_OUT.
REQ-002 Parameter TMO, default 16, maximum owner tenure in cycles (used only when ARB_TIMEOUT_EN is defined).
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 REQ  in  8  per-requester request, level-held until granted and served.
REQ-006 REL  in  1  release strobe from the current owner; ignored when no owner.
REQ-007 D0..D7  in  n each  requester data words.
REQ-008 GNT  out  8  one-hot grant, registered.
REQ-009 SEL  out  3  binary index of the current owner, registered; drives the shared 8:1 select.
REQ-010 BUSY  out  1  high while an owner exists.
REQ-011 D_OUT  out  n  registered copy of the selected data word.
REQ-012 D_VALID  out  1  high when D_OUT holds owner data.

Function
REQ-013 FSM states: IDLE (no owner) and OWN (one owner); encoding from the shared package.
REQ-014 IDLE with REQ==0: stay in IDLE; GNT=0, BUSY=0.
REQ-015 IDLE with REQ!=0: next edge enters OWN with owner = first set REQ bit searching upward (mod 8) from LAST+1; one-cycle request-to-grant latency.
REQ-016 LAST: 3-bit register, updated to the owner index on every grant.
REQ-017 In OWN: GNT one-hot at bit SEL; BUSY=1; SEL constant for the whole tenure.
REQ-018 Data path: each OWN cycle D_OUT <= D[SEL]; D_VALID is SEL-to-D_OUT delayed one cycle (D_VALID=1 the cycle after the first OWN cycle, through one cycle after tenure ends).
REQ-019 Release condition: REL=1, or REQ[SEL]=0.
REQ-020 Release with other REQ bits set (excluding the owner's): next edge grants the next requester round-robin directly, with no IDLE bubble; GNT is never zero and never multi-hot at that edge.
REQ-021 Release with no other requests: next edge returns to IDLE.
REQ-022 Owner REQ still high on release: treated as a new request at lowest round-robin priority.
REQ-023 REL and a new REQ on the same cycle: release is evaluated first, then arbitration runs over the updated REQ vector.
REQ-024 GNT is never multi-hot in any cycle.

Reset
REQ-025 RST_N low at any time, including mid-tenure: immediately forces IDLE, GNT=0, SEL=0, BUSY=0, D_OUT=0, D_VALID=0, LAST=7 (so requester 0 wins first), timeout counter=0.
REQ-026 Reset deassertion is synchronized by the integrator; the block does not resynchronize it.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: an owner-tenure counter is compiled in.
  - Counter clears on each grant and increments each OWN cycle.
  - At count TMO-1 the grant is forcibly released as in REQ-020/021.
  - Revoked owner moves to lowest priority.
REQ-028 ARB_TIMEOUT_EN undefined: no counter logic; tenure is unbounded; TMO is unused.

Structure
REQ-029 Shared package arb_pkg holds the state encodings (IDLE, OWN), the constant NREQ=8, and the default TMO.
REQ-030 Sub-module rr_pick8 is combinational.
  - Inputs: req[7:0], last[2:0], excl[7:0].
  - Outputs: any, idx[2:0].
  - Instantiated once.
REQ-031 The data selection reuses the team 8:1 mux block with parameter n, driven by the registered SEL.

Verification
REQ-032 Reset then REQ=8'h05 -> next edge GNT=8'h01, SEL=0; the edge after, D_OUT=D0 and D_VALID=1.
REQ-033 Owner 0 pulses REL with REQ=8'h05 still held -> next edge GNT=8'h04, SEL=2, with no GNT=0 cycle.
REQ-034 Fairness: REQ=8'hFF constant, REL pulsed each tenure -> SEL sequence 0,1,2,...,7,0 with no repeats.
REQ-035 Owner 3 drops REQ with REQ otherwise 0 -> next edge IDLE, GNT=0, BUSY=0; D_VALID falls one cycle later.
REQ-036 RST_N asserted mid-tenure (SEL=5) -> all outputs zero asynchronously; after release with REQ=8'h20, GNT=8'h20.
REQ-037 With ARB_TIMEOUT_EN and TMO=4, REQ=8'h03 held and no REL -> owner 0 for 4 cycles, then GNT=8'h02.
